// File: rtl/adc_serial_responder.sv
// adc_serial_responder
//
// Stands in for a 16-bit serial ADC so the capture path and servo controller
// can run without the physical converter. Each frame is LEAD_ZEROS zero bits
// followed by a DATA_BITS sample, MSB first. The external master drives cs
// (active-low) and sclk. Both are asynchronous to Clock_Nexys and are
// synchronized here. Data changes after sclk falling edges so the master can
// sample it on rising edges.
//
// Ports:
//   Clock_Nexys   system clock; all logic on the rising edge
//   Reset         asynchronous, active-high; clears all state
//   sclk          serial clock from the master (asynchronous)
//   cs            chip select from the master, active-low (asynchronous)
//   sample_in     sample value to be sent
//   sample_valid  one-cycle strobe; loads sample_in into sample_held
//   data_ADC      registered serial data to the master
//   busy          high while a frame is being shifted out
//   frame_done    one-cycle pulse after the last bit has been clocked out
//   overrun       sticky; a held sample was replaced before any frame used it
//   sample_held   last loaded sample
module adc_serial_responder #(
    parameter int  LEAD_ZEROS = 4,
    parameter int  DATA_BITS  = 12,
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS
) (
    input  logic                 Clock_Nexys,
    input  logic                 Reset,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 data_ADC,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [DATA_BITS-1:0] sample_held
);

    localparam int CNT_W = $clog2(FRAME_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_t;

    // Two synchronizer stages plus one history stage per input.
    logic cs_sync1_q, cs_sync2_q, cs_prev_q;
    logic cs_sync1_d, cs_sync2_d, cs_prev_d;
    logic sclk_sync1_q, sclk_sync2_q, sclk_prev_q;
    logic sclk_sync1_d, sclk_sync2_d, sclk_prev_d;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  held_q, held_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cs_fall, cs_rise, sclk_fall;
    logic [DATA_BITS-1:0]  snapshot;

    // Synchronizer chains; reset to the idle levels of the bus (cs and sclk high).
    always_comb begin
        cs_sync1_d   = cs;
        cs_sync2_d   = cs_sync1_q;
        cs_prev_d    = cs_sync2_q;
        sclk_sync1_d = sclk;
        sclk_sync2_d = sclk_sync1_q;
        sclk_prev_d  = sclk_sync2_q;
    end

    assign cs_fall   =  cs_prev_q   & ~cs_sync2_q;
    assign cs_rise   = ~cs_prev_q   &  cs_sync2_q;
    assign sclk_fall =  sclk_prev_q & ~sclk_sync2_q;

    // Next-state logic: sample holding, frame FSM and registered outputs.
    // An incoming strobe in the same cycle as cs_fall bypasses the holding
    // register so the freshest value goes into the frame about to start.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        snapshot  = sample_valid ? sample_in : held_q;

        if (sample_valid) begin
            held_d    = sample_in;
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end
        // A frame start consumes whatever is held, including a same-cycle strobe.
        if (cs_fall) begin
            pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    shift_d = {{LEAD_ZEROS{1'b0}}, snapshot};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // cs_rise outranks a simultaneous sclk_fall so an abort is never missed.
                if (cs_rise) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_fall && !cs_sync2_q) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = WAIT_CS;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the next state so the first bit appears with busy.
        busy_d = (state_d == SHIFT);
        data_d = (state_d == SHIFT) ? shift_d[FRAME_BITS-1] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge Clock_Nexys or posedge Reset) begin
        if (Reset) begin
            cs_sync1_q   <= 1'b1;
            cs_sync2_q   <= 1'b1;
            cs_prev_q    <= 1'b1;
            sclk_sync1_q <= 1'b1;
            sclk_sync2_q <= 1'b1;
            sclk_prev_q  <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            held_q       <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            data_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cs_sync1_q   <= cs_sync1_d;
            cs_sync2_q   <= cs_sync2_d;
            cs_prev_q    <= cs_prev_d;
            sclk_sync1_q <= sclk_sync1_d;
            sclk_sync2_q <= sclk_sync2_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_ADC    = data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;
    assign sample_held = held_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Testbench for adc_serial_responder: acts as the serial master (sclk idles
// low, data sampled on sclk rising edges), keeps a small model of the held
// sample / pending / overrun state, and scores received frames against a
// queue of expected words pushed when each frame is started.
module tb_adc_serial_responder;

    logic        Clock_Nexys = 1'b0;
    logic        Reset;
    logic        sclk;
    logic        cs;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        data_ADC;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [11:0] sample_held;

    adc_serial_responder dut (
        .Clock_Nexys  (Clock_Nexys),
        .Reset        (Reset),
        .sclk         (sclk),
        .cs           (cs),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .data_ADC     (data_ADC),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .sample_held  (sample_held)
    );

    always #5 Clock_Nexys = ~Clock_Nexys;

    int vectors     = 0;
    int miscompares = 0;

    // Cycle counter and frame_done monitor.
    int cyc       = 0;
    int doneCount = 0;
    int doneCyc   = 0;
    logic doneBusy = 1'b0;

    always @(posedge Clock_Nexys) cyc++;

    always @(negedge Clock_Nexys) begin
        if (frame_done === 1'b1) begin
            doneCount++;
            doneCyc  = cyc;
            doneBusy = busy;
        end
    end

    // Scoreboard and reference model.
    logic [15:0] expQ[$];
    logic [11:0] modelHeld;
    bit          modelPending;
    bit          modelOverrun;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadSample(input logic [11:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        if (modelPending) modelOverrun = 1'b1;
        modelHeld    = v;
        modelPending = 1'b1;
        @(negedge Clock_Nexys);
        sample_valid = 1'b0;
    endtask

    // Runs one master frame. abortAfter/resetAfter/updateAfter are falling
    // edge numbers (0 = unused).
    task automatic applyStimulus(input string name, input int nPeriods,
                                 input int abortAfter, input int resetAfter,
                                 input int updateAfter, input logic [11:0] updateVal,
                                 input bit bypass, input logic [11:0] bypassVal);
        logic [15:0] rx;
        logic [15:0] expFrame;
        int falls;
        int doneBefore;
        int fallCyc16;
        bit stopped;
        rx         = '0;
        falls      = 0;
        fallCyc16  = 0;
        stopped    = 1'b0;
        doneBefore = doneCount;

        cs = 1'b0;
        repeat (2) @(negedge Clock_Nexys);
        // cs_fall is seen by the DUT during the next cycle.
        if (bypass) begin
            sample_in    = bypassVal;
            sample_valid = 1'b1;
            if (modelPending) modelOverrun = 1'b1;
            modelHeld = bypassVal;
        end
        modelPending = 1'b0;
        expQ.push_back({4'h0, modelHeld});
        checkOutput({name, ".busy_early"}, 32'(busy), 32'd0);
        @(negedge Clock_Nexys);
        sample_valid = 1'b0;
        checkOutput({name, ".busy_start"}, 32'(busy), 32'd1);
        checkOutput({name, ".lead_bit"}, 32'(data_ADC), 32'd0);
        @(negedge Clock_Nexys);

        for (int p = 1; p <= nPeriods && !stopped; p++) begin
            sclk = 1'b1;
            if (p <= 16) rx[16-p] = data_ADC;
            else checkOutput({name, ".extra_bit"}, 32'(data_ADC), 32'd0);
            repeat (4) @(negedge Clock_Nexys);
            sclk = 1'b0;
            falls++;
            if (falls == 16) fallCyc16 = cyc;
            if (falls == resetAfter) begin
                repeat (2) @(negedge Clock_Nexys);
                Reset = 1'b1;
                #1;
                checkOutput({name, ".rst_data"}, 32'(data_ADC), 32'd0);
                checkOutput({name, ".rst_busy"}, 32'(busy), 32'd0);
                checkOutput({name, ".rst_done"}, 32'(frame_done), 32'd0);
                checkOutput({name, ".rst_overrun"}, 32'(overrun), 32'd0);
                checkOutput({name, ".rst_held"}, 32'(sample_held), 32'd0);
                @(negedge Clock_Nexys);
                Reset        = 1'b0;
                cs           = 1'b1;
                modelHeld    = '0;
                modelPending = 1'b0;
                modelOverrun = 1'b0;
                void'(expQ.pop_back());
                stopped = 1'b1;
            end else if (falls == abortAfter) begin
                repeat (4) @(negedge Clock_Nexys);
                cs = 1'b1;
                repeat (4) @(negedge Clock_Nexys);
                checkOutput({name, ".abort_busy"}, 32'(busy), 32'd0);
                checkOutput({name, ".abort_data"}, 32'(data_ADC), 32'd0);
                checkOutput({name, ".abort_done"}, 32'(doneCount - doneBefore), 32'd0);
                void'(expQ.pop_back());
                stopped = 1'b1;
            end else if (falls == updateAfter) begin
                loadSample(updateVal);
                repeat (3) @(negedge Clock_Nexys);
            end else begin
                repeat (4) @(negedge Clock_Nexys);
            end
        end

        if (!stopped) begin
            cs = 1'b1;
            repeat (6) @(negedge Clock_Nexys);
            checkOutput({name, ".end_busy"}, 32'(busy), 32'd0);
            checkOutput({name, ".end_data"}, 32'(data_ADC), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput({name, ".queue_empty"}, 32'd1, 32'd0);
            end else begin
                expFrame = expQ.pop_front();
                checkOutput({name, ".frame"}, 32'(rx), 32'(expFrame));
            end
            checkOutput({name, ".done_count"}, 32'(doneCount - doneBefore), 32'd1);
            checkOutput({name, ".done_latency"}, 32'(doneCyc - fallCyc16), 32'd3);
            checkOutput({name, ".busy_at_done"}, 32'(doneBusy), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset        = 1'b1;
        cs           = 1'b1;
        sclk         = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        modelHeld    = '0;
        modelPending = 1'b0;
        modelOverrun = 1'b0;
        repeat (3) @(negedge Clock_Nexys);
        checkOutput("reset.data", 32'(data_ADC), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(frame_done), 32'd0);
        checkOutput("reset.overrun", 32'(overrun), 32'd0);
        checkOutput("reset.held", 32'(sample_held), 32'd0);
        Reset = 1'b0;
        repeat (4) @(negedge Clock_Nexys);

        $display("[TB] basic frame");
        loadSample(12'hA5C);
        repeat (2) @(negedge Clock_Nexys);
        applyStimulus("basic", 16, 0, 0, 0, 12'h000, 1'b0, 12'h000);
        checkOutput("basic.overrun", 32'(overrun), 32'(modelOverrun));

        $display("[TB] mid-frame update");
        loadSample(12'h123);
        repeat (2) @(negedge Clock_Nexys);
        applyStimulus("midupd", 16, 0, 0, 6, 12'hFFF, 1'b0, 12'h000);
        checkOutput("midupd.held", 32'(sample_held), 32'(modelHeld));
        applyStimulus("midupd_next", 16, 0, 0, 0, 12'h000, 1'b0, 12'h000);
        checkOutput("midupd.overrun", 32'(overrun), 32'(modelOverrun));

        $display("[TB] same-cycle bypass");
        applyStimulus("bypass", 16, 0, 0, 0, 12'h000, 1'b1, 12'h800);
        checkOutput("bypass.held", 32'(sample_held), 32'(modelHeld));

        $display("[TB] abort");
        applyStimulus("abort", 16, 9, 0, 0, 12'h000, 1'b0, 12'h000);
        loadSample(12'h3A7);
        repeat (2) @(negedge Clock_Nexys);
        applyStimulus("postabort", 16, 0, 0, 0, 12'h000, 1'b0, 12'h000);

        $display("[TB] overrun and extra clocks");
        loadSample(12'h001);
        repeat (2) @(negedge Clock_Nexys);
        loadSample(12'h002);
        repeat (2) @(negedge Clock_Nexys);
        checkOutput("ovr.flag", 32'(overrun), 32'(modelOverrun));
        applyStimulus("extra", 18, 0, 0, 0, 12'h000, 1'b0, 12'h000);
        checkOutput("ovr.flag_after", 32'(overrun), 32'(modelOverrun));
        applyStimulus("again", 16, 0, 0, 0, 12'h000, 1'b0, 12'h000);
        checkOutput("ovr.flag_sticky", 32'(overrun), 32'(modelOverrun));

        $display("[TB] reset mid-frame");
        applyStimulus("rstmid", 16, 0, 10, 0, 12'h000, 1'b0, 12'h000);
        repeat (4) @(negedge Clock_Nexys);
        loadSample(12'h3C3);
        repeat (2) @(negedge Clock_Nexys);
        applyStimulus("postrst", 16, 0, 0, 0, 12'h000, 1'b0, 12'h000);
        checkOutput("postrst.overrun", 32'(overrun), 32'(modelOverrun));
        checkOutput("postrst.held", 32'(sample_held), 32'(modelHeld));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

- Synthesizable responder for the 16-bit serial ADC frame: 4 leading zeros followed by a 12-bit sample, MSB first.
- Driven by an external master's chip select and serial clock.
- Lets the ADC capture path and servo controller be exercised in hardware loopback or on a bench without the physical converter.
- All logic runs on the single board clock. SCLK and CS are treated as asynchronous inputs and synchronized internally.

## Interface

Parameters:
- LEAD_ZEROS, 4, number of zero bits sent before the sample.
- DATA_BITS, 12, sample width.
- FRAME_BITS, LEAD_ZEROS+DATA_BITS (16), total bits per frame; derived, do not override.

Ports:
- Clock_Nexys  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- sclk  input  1  serial clock from the master; asynchronous to Clock_Nexys.
- cs  input  1  chip select from the master, active-low; asynchronous.
- sample_in  input  DATA_BITS  value to be sent.
- sample_valid  input  1  one-cycle strobe; loads sample_in into sample_held.
- data_ADC  output  1  serial data to the master (registered).
- busy  output  1  high while a frame is in progress (SHIFT state).
- frame_done  output  1  one-cycle pulse when the last bit has been clocked out.
- overrun  output  1  sticky; a sample was replaced before any frame started.
- sample_held  output  DATA_BITS  last loaded sample.

## Operation

- **Input synchronization**
  - sclk and cs each pass through 2 flops, plus a third flop for edge detection.
  - cs_fall: the synchronized cs goes 1→0.
  - cs_rise: the synchronized cs goes 0→1.
  - sclk_fall: the synchronized sclk goes 1→0.
- **sample_held**
  - Loads sample_in on every cycle where sample_valid=1, in any state.
  - A pending flag is set on load and cleared on cs_fall.
  - If sample_valid arrives while pending=1, overrun is set. It stays set until Reset.
- **IDLE**
  - data_ADC=0, busy=0.
  - On cs_fall:
    - The shift register loads {LEAD_ZEROS zeros, snapshot}. The snapshot is sample_in if sample_valid=1 in the same cycle, otherwise sample_held.
    - The bit counter is cleared. The FSM goes to SHIFT.
- **SHIFT**
  - data_ADC = shift register MSB; busy=1.
  - On sclk_fall: shift left by one, counter+1.
  - When the counter reaches FRAME_BITS: pulse frame_done, drive data_ADC=0, go to WAIT_CS.
  - On cs_rise before that point: abort. Go to IDLE with no frame_done; the counter clears.
  - sclk edges are ignored when cs is high.
- **WAIT_CS**
  - data_ADC=0, busy=0.
  - Further sclk_fall edges are ignored. This covers a master that clocks 17 or more bits.
  - On cs_rise: go to IDLE.
- If cs_rise and sclk_fall are detected in the same cycle, cs_rise wins (abort).
- The frame snapshot is fixed at cs_fall. sample_valid during SHIFT updates only sample_held and is sent in the next frame.
- Counter width is clog2(FRAME_BITS)+1. It never wraps; SHIFT exits at FRAME_BITS.

## Timing

- Reset values:
  - data_ADC=0, busy=0, frame_done=0, overrun=0, sample_held=0.
  - FSM=IDLE, pending=0, counter=0, synchronizer flops at idle levels (cs=1, sclk=1).
- cs pin falling to first bit (leading zero) valid on data_ADC: 3 Clock_Nexys cycles. busy rises in the same cycle.
- sclk pin falling to next bit on data_ADC: 3 Clock_Nexys cycles.
- The master samples on the sclk rising edge. The first data bit (sample MSB) is therefore driven after the 4th falling edge.
- sclk high and low times must each be at least 4 Clock_Nexys cycles. Behaviour with faster sclk is undefined.
- frame_done is asserted 3 cycles after the 16th sclk falling edge at the pin, for exactly 1 cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately. The next frame starts only after a fresh cs_fall.

## Test plan

- **Basic frame**: Reset; load sample 12'hA5C; drop cs; 16 sclk periods of 8 cycles each; sample on rising edges.
  - Master receives 16'h0A5C, MSB first.
  - frame_done pulses once, 3 cycles after the 16th falling edge.
  - busy falls with frame_done.
- **Mid-frame update**: load 12'h123; start a frame; pulse sample_valid with 12'hFFF after bit 6.
  - Frame returns 16'h0123; sample_held=12'hFFF.
  - Next frame returns 16'h0FFF; overrun=0.
- **Same-cycle bypass**: sample_valid with 12'h800 in the same cycle cs_fall is detected.
  - Frame returns 16'h0800.
- **Abort**: raise cs after 9 sclk falling edges.
  - FSM returns to IDLE; no frame_done; data_ADC=0.
  - The next full frame returns the correct 16 bits.
- **Overrun and extra clocks**: two sample_valid strobes (12'h001, then 12'h002) with no frame in between.
  - overrun=1 and stays 1 through later frames.
  - A frame with 18 sclk edges returns 16'h0002; bits 17–18 read 0; a single frame_done.
- **Reset mid-frame**: assert Reset during bit 10.
  - All outputs are 0 in the same cycle. After release and a new frame with 12'h3C3 loaded, the master receives 16'h03C3.
